// File: rtl/bitserial_addsub_seq.sv
// Bit-serial WIDTH-bit adder/subtractor: one full-adder cell is stepped LSB-first
// once per cycle, with a registered carry loop and valid/ready handshakes.
module bitserial_addsub_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             busy
);

  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             cflop_q, cflop_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             overflow_q, overflow_d;
  logic             zero_q, zero_d;
  logic             busy_q, busy_d;

  logic             fa_sum;
  logic             fa_cout;
  logic             last_bit;

  // The single full-adder cell shared by every bit position
  assign fa_sum   = a_q[0] ^ b_q[0] ^ cflop_q;
  assign fa_cout  = (a_q[0] & b_q[0]) | (cflop_q & (a_q[0] ^ b_q[0]));
  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      cflop_q    <= 1'b0;
      result_q   <= '0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      a_q        <= a_d;
      b_q        <= b_d;
      cflop_q    <= cflop_d;
      result_q   <= result_d;
      carry_q    <= carry_d;
      overflow_q <= overflow_d;
      zero_q     <= zero_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    cflop_d    = cflop_q;
    result_d   = result_q;
    carry_d    = carry_q;
    overflow_d = overflow_q;
    zero_d     = zero_q;

    // flush wins over both accept and result handshake
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            a_d     = a;
            b_d     = sub ? ~b : b;
            cflop_d = sub;
            cnt_d   = '0;
            state_d = S_RUN;
          end
        end
        S_RUN: begin
          a_d      = a_q >> 1;
          b_d      = b_q >> 1;
          cflop_d  = fa_cout;
          cnt_d    = cnt_q + CW'(1);
          result_d = {fa_sum, result_q[WIDTH-1:1]};
          if (last_bit) begin
            // cflop_q is the carry into the MSB on this final step
            carry_d    = fa_cout;
            overflow_d = cflop_q ^ fa_cout;
            zero_d     = ({fa_sum, result_q[WIDTH-1:1]} == '0);
            cnt_d      = '0;
            state_d    = S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    busy_d = (state_d == S_RUN);
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;
  assign carry     = carry_q;
  assign overflow  = overflow_q;
  assign zero      = zero_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_bitserial_addsub_seq.sv
// Self-checking bench for bitserial_addsub_seq against an arithmetic reference model.
module tb_bitserial_addsub_seq;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         flush;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         carry;
  logic         overflow;
  logic         zero;
  logic         busy;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  bitserial_addsub_seq #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .sub      (sub),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .carry    (carry),
    .overflow (overflow),
    .zero     (zero),
    .busy     (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [W-1:0] r;
    logic         c;
    logic         v;
    logic         z;
  } exp_t;

  // Reference: plain unsigned/signed arithmetic on wide integers
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    exp_t   e;
    longint sx, sy, st;
    longint smax, smin;
    logic [W:0] usum;
    sx   = longint'(signed'(x));
    sy   = longint'(signed'(y));
    smax = (longint'(1) <<< (W - 1)) - 1;
    smin = -(longint'(1) <<< (W - 1));
    if (s) begin
      e.r = x - y;
      e.c = (x >= y);
      st  = sx - sy;
    end else begin
      usum = {1'b0, x} + {1'b0, y};
      e.r  = usum[W-1:0];
      e.c  = usum[W];
      st   = sx + sy;
    end
    e.v = (st > smax) || (st < smin);
    e.z = (e.r == '0);
    return e;
  endfunction

  task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    a = x; b = y; sub = s; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0;
    flush = 1'b0; out_ready = 1'b0;
    #12;
    n_vec++;
    if ({result, carry, overflow, zero, out_valid, busy, in_ready} !== {{W{1'b0}}, 6'b000001}) begin
      n_err++;
      $display("FAIL reset_state: got res=%h c=%b v=%b z=%b ov=%b busy=%b ir=%b want all 0, in_ready=1",
               result, carry, overflow, zero, out_valid, busy, in_ready);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_arith;
    logic [W-1:0] xa[$];
    logic [W-1:0] xb[$];
    logic         xs[$];
    exp_t e;
    int lat;
    xa = '{32'd5, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'd3, 32'h8000_0000, 32'h8000_0000};
    xb = '{32'd7, 32'd1,         32'd1,         32'd5, 32'd5, 32'd1,         32'h8000_0000};
    xs = '{1'b0,  1'b0,          1'b0,          1'b1,  1'b1,  1'b1,          1'b0};
    for (int i = 0; i < 20; i++) begin
      xa.push_back((i % 4 == 0) ? 32'hFFFF_FFFF - $urandom_range(0, 3) : $urandom);
      xb.push_back((i % 5 == 0) ? $urandom_range(0, 3) : $urandom);
      xs.push_back($urandom_range(0, 1) == 1);
    end
    for (int i = 0; i < xa.size(); i++) begin
      e = model(xa[i], xb[i], xs[i]);
      start_op(xa[i], xb[i], xs[i]);
      n_vec++;
      if (busy !== 1'b1 || in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL run_flags[%0d]: got busy=%b in_ready=%b want 1/0", i, busy, in_ready);
      end
      wait_done(lat);
      n_vec++;
      if (lat !== 32) begin
        n_err++;
        $display("FAIL latency[%0d]: got %0d want 32", i, lat);
      end
      n_vec++;
      if ({result, carry, overflow, zero, busy} !== {e.r, e.c, e.v, e.z, 1'b0}) begin
        n_err++;
        $display("FAIL result[%0d] a=%h b=%h sub=%b: got r=%h c=%b v=%b z=%b busy=%b want r=%h c=%b v=%b z=%b busy=0",
                 i, xa[i], xb[i], xs[i], result, carry, overflow, zero, busy, e.r, e.c, e.v, e.z);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      n_vec++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL ack[%0d]: got in_ready=%b out_valid=%b want 1/0", i, in_ready, out_valid);
      end
    end
  endtask

  task automatic test_backpressure;
    exp_t e;
    int lat;
    e = model(32'h1234_5678, 32'h0FED_CBA9, 1'b1);
    start_op(32'h1234_5678, 32'h0FED_CBA9, 1'b1);
    wait_done(lat);
    a = 32'hDEAD_BEEF; b = 32'h1; sub = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      n_vec++;
      if ({out_valid, in_ready, result, carry, overflow, zero} !== {2'b10, e.r, e.c, e.v, e.z}) begin
        n_err++;
        $display("FAIL hold[%0d]: got ov=%b ir=%b r=%h c=%b v=%b z=%b want ov=1 ir=0 r=%h c=%b v=%b z=%b",
                 i, out_valid, in_ready, result, carry, overflow, zero, e.r, e.c, e.v, e.z);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_vec++;
    if ({in_ready, out_valid, result} !== {2'b10, e.r}) begin
      n_err++;
      $display("FAIL release: got ir=%b ov=%b r=%h want ir=1 ov=0 r=%h", in_ready, out_valid, result, e.r);
    end
  endtask

  task automatic test_reset_mid_run;
    exp_t e;
    int lat;
    start_op(32'hAAAA_5555, 32'h1111_2222, 1'b0);
    repeat (9) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({result, carry, overflow, zero, out_valid, busy, in_ready} !== {{W{1'b0}}, 6'b000001}) begin
      n_err++;
      $display("FAIL reset_mid_run: got res=%h c=%b v=%b z=%b ov=%b busy=%b ir=%b want all 0, in_ready=1",
               result, carry, overflow, zero, out_valid, busy, in_ready);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    e = model(32'd1, 32'd1, 1'b0);
    start_op(32'd1, 32'd1, 1'b0);
    wait_done(lat);
    n_vec++;
    if (lat !== 32 || result !== e.r) begin
      n_err++;
      $display("FAIL after_reset_op: got lat=%0d r=%h want lat=32 r=%h", lat, result, e.r);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_flush;
    bit seen;
    int lat;
    start_op(32'h0000_FFFF, 32'h0000_0001, 1'b0);
    repeat (4) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    n_vec++;
    if ({in_ready, busy, out_valid} !== 3'b100) begin
      n_err++;
      $display("FAIL flush_run: got ir=%b busy=%b ov=%b want 1/0/0", in_ready, busy, out_valid);
    end
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    n_vec++;
    if (seen !== 1'b0) begin
      n_err++;
      $display("FAIL flush_no_result: got out_valid seen=%b want 0", seen);
    end
    a = 32'd9; b = 32'd9; sub = 1'b0; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    n_vec++;
    if ({in_ready, busy} !== 2'b10) begin
      n_err++;
      $display("FAIL flush_idle: got ir=%b busy=%b want 1/0", in_ready, busy);
    end
    start_op(32'd2, 32'd3, 1'b0);
    wait_done(lat);
    out_ready = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; flush = 1'b0;
    n_vec++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      n_err++;
      $display("FAIL flush_done: got ir=%b ov=%b busy=%b want 1/0/0", in_ready, out_valid, busy);
    end
  endtask

  task automatic test_back_to_back;
    exp_t q[$];
    exp_t e;
    int   t_done[$];
    int   guard;
    in_valid = 1'b1; out_ready = 1'b1;
    guard = 0;
    while (t_done.size() < 3 && guard < 300) begin
      if (out_valid) begin
        t_done.push_back(cyc);
        e = q.pop_front();
        n_vec++;
        if ({result, carry, overflow, zero} !== {e.r, e.c, e.v, e.z}) begin
          n_err++;
          $display("FAIL b2b_result[%0d]: got r=%h c=%b v=%b z=%b want r=%h c=%b v=%b z=%b",
                   t_done.size() - 1, result, carry, overflow, zero, e.r, e.c, e.v, e.z);
        end
        if (t_done.size() == 3) in_valid = 1'b0;
      end else if (in_ready) begin
        a = $urandom; b = $urandom; sub = $urandom_range(0, 1) == 1;
        q.push_back(model(a, b, sub));
      end
      @(posedge clk); #1;
      guard++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    n_vec++;
    if (t_done.size() !== 3) begin
      n_err++;
      $display("FAIL b2b_count: got %0d results want 3", t_done.size());
    end else begin
      for (int i = 1; i < 3; i++) begin
        n_vec++;
        if (t_done[i] - t_done[i-1] !== 34) begin
          n_err++;
          $display("FAIL b2b_interval[%0d]: got %0d cycles want 34", i, t_done[i] - t_done[i-1]);
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_arith;
    test_backpressure;
    test_reset_mid_run;
    test_flush;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
